// File: rtl/button_event_source_pkg.sv
// Shared definitions for the button event source: per-button FSM encoding,
// default debounce/repeat timing at 50 MHz, and button bit positions.
package button_event_source_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEF_NUM_BTN         = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;
    localparam int DEF_CNT_WIDTH       = 25;

    localparam int BTN_EAST  = 3;
    localparam int BTN_WEST  = 2;
    localparam int BTN_NORTH = 1;
    localparam int BTN_SOUTH = 0;

endpackage

// File: rtl/button_event_source_if.sv
// Button/core signal bundle: raw buttons and acks toward the block,
// event/level/overrun flags back to the core.
interface button_event_source_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] iButton;
    logic [NUM_BTN-1:0] iAck;
    logic [NUM_BTN-1:0] oEvent;
    logic [NUM_BTN-1:0] oLevel;
    logic [NUM_BTN-1:0] oOverrun;

    modport master (output iButton, output iAck,
                    input  oEvent, input oLevel, input oOverrun);
    modport slave  (input  iButton, input iAck,
                    output oEvent, output oLevel, output oOverrun);
endinterface

// File: rtl/button_event_source_button_debounce_fsm.sv
// One button: 2-flop synchronizer, debounce FSM with auto-repeat, registered
// debounced level and a one-cycle set pulse for the event flag.
module button_debounce_fsm
    import button_event_source_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic button_i,
    output logic level_o,
    output logic set_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] RPT_FIRST = CNT_WIDTH'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] RPT_NEXT  = CNT_WIDTH'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
    localparam bit                   RPT_EN    = (REPEAT_DELAY != 0);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_dec(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? v : v - CNT_ONE;
    endfunction

    logic                 sync1_q, sync_q;
    btn_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] rpt_q, rpt_d;
    logic                 level_q, level_d;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            rpt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= button_i;
            sync_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            level_q <= level_d;
        end
    end

    // The repeat counter counts down to zero; it only moves in HELD, so a
    // short release bounce resumes it exactly where it stopped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        level_d = level_q;
        set_o   = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (sync_q) begin
                    cnt_d   = '0;
                    state_d = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = ST_RELEASED;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = ST_HELD;
                    level_d = 1'b1;
                    set_o   = 1'b1;
                    rpt_d   = RPT_FIRST;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_HELD: begin
                if (!sync_q) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE_WAIT;
                end else if (RPT_EN) begin
                    if (rpt_q == '0) begin
                        set_o = 1'b1;
                        rpt_d = RPT_NEXT;
                    end else begin
                        rpt_d = sat_dec(rpt_q);
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync_q) begin
                    state_d = ST_HELD;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = ST_RELEASED;
                    level_d = 1'b0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
        endcase
    end

    assign level_o = level_q;

endmodule

// File: rtl/button_event_source.sv
// Top: one debounce FSM per button plus the sticky event/overrun flags that
// the core consumes with per-button ack pulses.
module button_event_source
    import button_event_source_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    button_event_source_if.slave  bus
);

    logic [NUM_BTN-1:0] set_w;
    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] event_q, event_d;
    logic [NUM_BTN-1:0] overrun_q, overrun_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_fsm (
            .Clock    (Clock),
            .Reset_n  (Reset_n),
            .button_i (bus.iButton[i]),
            .level_o  (level_w[i]),
            .set_o    (set_w[i])
        );
    end

    // A set wins over a coincident ack, but the ack still counts as having
    // consumed the previous event, so overrun is cleared in that case.
    always_comb begin
        event_d   = event_q;
        overrun_d = overrun_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (set_w[i]) begin
                event_d[i] = 1'b1;
                if (bus.iAck[i]) begin
                    overrun_d[i] = 1'b0;
                end else if (event_q[i]) begin
                    overrun_d[i] = 1'b1;
                end
            end else if (bus.iAck[i] && event_q[i]) begin
                event_d[i]   = 1'b0;
                overrun_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            event_q   <= '0;
            overrun_q <= '0;
        end else begin
            event_q   <= event_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.oEvent   = event_q;
    assign bus.oLevel   = level_w;
    assign bus.oOverrun = overrun_q;

endmodule
